// File: rtl/req_encoder_serial_pkg.sv
// Shared types and defaults for the serial request encoder.
package req_encoder_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam int unsigned W_DEFAULT = 2;

endpackage

// File: rtl/req_encoder_serial_prio_enc.sv
// Combinational priority encoder: index of the highest set bit plus a one-hot flag.
module prio_enc #(
  parameter int unsigned W = 2
) (
  input  logic [2**W-1:0] vec,
  output logic [W-1:0]    idx,
  output logic            one_hot
);

  localparam int unsigned N = 2**W;

  always_comb begin
    idx = '0;
    // Ascending scan: the last set bit seen is the highest one.
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
    one_hot = ($countones(vec) == 1);
  end

endmodule

// File: rtl/req_encoder_serial.sv
// Captures a request vector and emits the code of each set bit, highest first.
// Optional REQ_ENC_MULTI_FLAG_EN adds a registered 'multi' output (more than one request captured).
module req_encoder_serial
  import req_encoder_serial_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**W-1:0] req,
  input  logic            req_valid,
  output logic            req_ready,
  output logic [W-1:0]    code,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef REQ_ENC_MULTI_FLAG_EN
  output logic            multi,
`endif
  output logic            out_last
);

  localparam int unsigned N = 2**W;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   code_q, code_d;
  logic           last_q, last_d;
  logic [N-1:0]   pending_nxt;
  logic [N-1:0]   enc_in;
  logic [W-1:0]   enc_idx;
  logic           enc_one_hot;
  logic           fire;
`ifdef REQ_ENC_MULTI_FLAG_EN
  logic           multi_q, multi_d;
`endif

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == SERVE);
  assign code      = code_q;
  assign out_last  = last_q;
  assign fire      = out_valid && out_ready;
`ifdef REQ_ENC_MULTI_FLAG_EN
  assign multi     = multi_q;
`endif

  // Encoding the post-clear vector lets the next code load on the handshake edge.
  always_comb begin
    pending_nxt = pending_q;
    if (fire) pending_nxt[code_q] = 1'b0;
    enc_in = (state_q == IDLE) ? req : pending_nxt;
  end

  prio_enc #(.W(W)) u_prio_enc (
    .vec     (enc_in),
    .idx     (enc_idx),
    .one_hot (enc_one_hot)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    code_d    = code_q;
    last_d    = last_q;
`ifdef REQ_ENC_MULTI_FLAG_EN
    multi_d   = multi_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid && (req != '0)) begin
          state_d   = SERVE;
          pending_d = req;
          code_d    = enc_idx;
          last_d    = enc_one_hot;
`ifdef REQ_ENC_MULTI_FLAG_EN
          multi_d   = !enc_one_hot;
`endif
        end
      end
      SERVE: begin
        pending_d = pending_nxt;
        if (fire) begin
          if (pending_nxt != '0) begin
            code_d = enc_idx;
            last_d = enc_one_hot;
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
`ifdef REQ_ENC_MULTI_FLAG_EN
            multi_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      last_q    <= 1'b0;
`ifdef REQ_ENC_MULTI_FLAG_EN
      multi_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      last_q    <= last_d;
`ifdef REQ_ENC_MULTI_FLAG_EN
      multi_q   <= multi_d;
`endif
    end
  end

endmodule

// File: tb/tb_req_encoder_serial.sv
// Scoreboard bench for req_encoder_serial: directed vectors, monitor checks every output handshake.
module tb_req_encoder_serial;

  localparam int unsigned W = 2;
  localparam int unsigned N = 2**W;

  typedef struct packed {
    logic [W-1:0] code;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] code;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
`ifdef REQ_ENC_MULTI_FLAG_EN
  logic         multi;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  req_encoder_serial #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .code      (code),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef REQ_ENC_MULTI_FLAG_EN
    .multi     (multi),
`endif
    .out_last  (out_last)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input bit l);
    exp_t e;
    e.code = W'(c);
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [N-1:0] v);
    check("req_ready_before_send", int'(req_ready), 1);
    req       = v;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req       = '0;
  endtask

  // Monitor: every output handshake is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got code %0d last %0d expected none at %0t",
                 code, out_last, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_code", int'(code), int'(e.code));
        check("out_last", int'(out_last), int'(e.last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset with a pending-looking request, nothing must be captured
    rst = 1'b1; req_valid = 1'b1; req = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_code", int'(code), 0);
    check("rst_out_last", int'(out_last), 0);
`ifdef REQ_ENC_MULTI_FLAG_EN
    check("rst_multi", int'(multi), 0);
`endif
    rst = 1'b0; req_valid = 1'b0; req = '0;
    check("rst_req_ready", int'(req_ready), 1);
    tick();
    check("post_rst_out_valid", int'(out_valid), 0);

    // 2: single request
    push(2, 1'b1);
    send(4'b0100);
    check("single_valid", int'(out_valid), 1);
    check("single_code", int'(code), 2);
    check("single_last", int'(out_last), 1);
    tick();
    check("single_done_valid", int'(out_valid), 0);
    check("single_done_ready", int'(req_ready), 1);

    // 3: three requests back to back
    push(3, 1'b0); push(1, 1'b0); push(0, 1'b1);
    send(4'b1011);
    check("multi_ready0", int'(req_ready), 0);
`ifdef REQ_ENC_MULTI_FLAG_EN
    check("multi_flag_set", int'(multi), 1);
`endif
    tick();
    check("multi_ready1", int'(req_ready), 0);
    check("multi_code1", int'(code), 1);
    tick();
    check("multi_ready2", int'(req_ready), 0);
    check("multi_code0", int'(code), 0);
    tick();
    check("multi_done_valid", int'(out_valid), 0);
    check("multi_done_ready", int'(req_ready), 1);
`ifdef REQ_ENC_MULTI_FLAG_EN
    check("multi_flag_clr", int'(multi), 0);
`endif

    // 4: backpressure holds code/last
    out_ready = 1'b0;
    push(1, 1'b0); push(0, 1'b1);
    send(4'b0011);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_code", int'(code), 1);
      check("bp_last", int'(out_last), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_code_after", int'(code), 0);
    check("bp_last_after", int'(out_last), 1);
    tick();
    check("bp_done_valid", int'(out_valid), 0);

    // 5: zero vector accepted and dropped
    send(4'b0000);
    check("zero_ready", int'(req_ready), 1);
    check("zero_valid", int'(out_valid), 0);
    tick();
    check("zero_valid2", int'(out_valid), 0);
    push(3, 1'b1);
    send(4'b1000);
    check("after_zero_code", int'(code), 3);
    tick();
    check("after_zero_done", int'(out_valid), 0);

    // 6: reset after the first handshake discards the rest
    push(3, 1'b0);
    send(4'b1111);
`ifdef REQ_ENC_MULTI_FLAG_EN
    check("mid_multi_set", int'(multi), 1);
`endif
    tick();
    rst = 1'b1; out_ready = 1'b0;
    check("mid_code_next", int'(code), 2);
    tick();
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_last", int'(out_last), 0);
`ifdef REQ_ENC_MULTI_FLAG_EN
    check("mid_multi_clr", int'(multi), 0);
`endif
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_no_output", int'(out_valid), 0);
    end
    check("mid_ready", int'(req_ready), 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
